// File: rtl/thread_scheduler_if.sv
`default_nettype none
// ============================================================================
// thread_scheduler_if
// Store read/write channel and consumer handshake for thread_scheduler.
// Revision: 1.0
// ============================================================================
interface thread_scheduler_if #(
   parameter int N_THREADS = 6,
   parameter int STATE_W   = 2
);
   localparam int NUM_W = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

   logic               scan_en;
   logic [NUM_W-1:0]   rd_num;
   logic [STATE_W-1:0] rd_state;
   logic               wr_en;
   logic [NUM_W-1:0]   wr_num;
   logic [STATE_W-1:0] wr_state;
   logic               out_valid;
   logic [NUM_W-1:0]   out_num;
   logic               out_ready;
   logic               none_rdy;

   modport master (
      input  scan_en, rd_state, out_ready,
      output rd_num, wr_en, wr_num, wr_state, out_valid, out_num, none_rdy
   );

   modport slave (
      output scan_en, rd_state, out_ready,
      input  rd_num, wr_en, wr_num, wr_state, out_valid, out_num, none_rdy
   );
endinterface
`default_nettype wire

// File: rtl/thread_scheduler.sv
`default_nettype none
// ============================================================================
// thread_scheduler
// Round-robin finder of threads in MATCH_STATE; offers them to a consumer and
// writes NEW_STATE back to the thread store on acceptance.
// Revision: 1.0
// ============================================================================
module thread_scheduler #(
   parameter int                 N_THREADS   = 6,
   parameter int                 STATE_W     = 2,
   parameter logic [STATE_W-1:0] MATCH_STATE = STATE_W'(1),
   parameter logic [STATE_W-1:0] NEW_STATE   = STATE_W'(2),
   parameter int                 HOLDOFF     = 2
) (
   input  wire logic            CLK,
   input  wire logic            reset,
   thread_scheduler_if.master   bus
);
   localparam int NUM_W  = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
   localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [NUM_W-1:0]  LAST      = NUM_W'(N_THREADS - 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF);

   typedef enum logic [1:0] {
      S_SCAN  = 2'd0,
      S_GRANT = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_W-1:0]   ptr_q, ptr_d;
   logic [NUM_W-1:0]   miss_q, miss_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               out_valid_q, out_valid_d;
   logic [NUM_W-1:0]   out_num_q, out_num_d;
   logic               wr_en_q, wr_en_d;
   logic [NUM_W-1:0]   wr_num_q, wr_num_d;
   logic               none_rdy_q, none_rdy_d;

   // Compare against the last index before adding so N_THREADS=64 cannot overflow
   function automatic logic [NUM_W-1:0] wrap_inc(input logic [NUM_W-1:0] p);
      return (p == LAST) ? '0 : p + NUM_W'(1);
   endfunction

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= S_SCAN;
         ptr_q       <= '0;
         miss_q      <= '0;
         hold_q      <= '0;
         out_valid_q <= 1'b0;
         out_num_q   <= '0;
         wr_en_q     <= 1'b0;
         wr_num_q    <= '0;
         none_rdy_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         miss_q      <= miss_d;
         hold_q      <= hold_d;
         out_valid_q <= out_valid_d;
         out_num_q   <= out_num_d;
         wr_en_q     <= wr_en_d;
         wr_num_q    <= wr_num_d;
         none_rdy_q  <= none_rdy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      miss_d      = miss_q;
      hold_d      = hold_q;
      out_valid_d = out_valid_q;
      out_num_d   = out_num_q;
      wr_en_d     = 1'b0;
      wr_num_d    = wr_num_q;
      none_rdy_d  = 1'b0;

      case (state_q)
         S_SCAN: begin
            if (bus.scan_en) begin
               if (bus.rd_state == MATCH_STATE) begin
                  out_num_d   = ptr_q;
                  out_valid_d = 1'b1;
                  miss_d      = '0;
                  state_d     = S_GRANT;
               end else begin
                  ptr_d = wrap_inc(ptr_q);
                  if (miss_q == LAST) begin
                     none_rdy_d = 1'b1;
                     miss_d     = '0;
                  end else begin
                     miss_d = miss_q + NUM_W'(1);
                  end
               end
            end
         end
         S_GRANT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               wr_en_d     = 1'b1;
               wr_num_d    = out_num_q;
               ptr_d       = wrap_inc(out_num_q);
               hold_d      = HOLD_INIT;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            // Wait out the store's write latency so a stale match is not re-read
            if (hold_q <= HOLD_W'(1)) begin
               hold_d  = '0;
               state_d = S_SCAN;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         default: begin
            state_d = S_SCAN;
         end
      endcase
   end

   assign bus.rd_num    = ptr_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_num    = wr_num_q;
   assign bus.wr_state  = NEW_STATE;
   assign bus.out_valid = out_valid_q;
   assign bus.out_num   = out_num_q;
   assign bus.none_rdy  = none_rdy_q;
endmodule
`default_nettype wire

// File: tb/tb_thread_scheduler.sv
`default_nettype none
// ============================================================================
// tb_thread_scheduler
// Self-checking bench for thread_scheduler with a behavioural thread store.
// Revision: 1.0
// ============================================================================
module tb_thread_scheduler;
   localparam int N       = 6;
   localparam int SW      = 2;
   localparam int HOLDOFF = 2;
   localparam logic [SW-1:0] MATCH = 2'd1;
   localparam logic [SW-1:0] NEWS  = 2'd2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   thread_scheduler_if #(.N_THREADS(N), .STATE_W(SW)) ifc ();
   thread_scheduler_if #(.N_THREADS(1), .STATE_W(SW)) ifc1 ();

   thread_scheduler #(
      .N_THREADS(N), .STATE_W(SW), .MATCH_STATE(MATCH), .NEW_STATE(NEWS), .HOLDOFF(HOLDOFF)
   ) dut (
      .CLK(clk), .reset(reset), .bus(ifc.master)
   );

   thread_scheduler #(
      .N_THREADS(1), .STATE_W(SW), .MATCH_STATE(MATCH), .NEW_STATE(NEWS), .HOLDOFF(HOLDOFF)
   ) dut1 (
      .CLK(clk), .reset(reset), .bus(ifc1.master)
   );

   // Thread store: registered write, combinational read
   logic [SW-1:0] mem [N];
   logic [SW-1:0] bulk_val [N];
   logic          bulk_en;
   always @(posedge clk) begin
      if (bulk_en) begin
         for (int i = 0; i < N; i++) mem[i] <= bulk_val[i];
      end else if (ifc.wr_en) begin
         mem[ifc.wr_num] <= ifc.wr_state;
      end
   end
   assign ifc.rd_state = mem[ifc.rd_num];

   logic [SW-1:0] mem1;
   logic          arm1;
   always @(posedge clk) begin
      if (ifc1.wr_en) mem1 <= ifc1.wr_state;
      if (arm1)       mem1 <= MATCH;
   end
   assign ifc1.rd_state = mem1;

   int errors = 0;
   int checks = 0;

   logic [SW-1:0] ref_mem [N];
   int m_ptr, m_miss;
   bit m_none;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic bit any_match();
      for (int i = 0; i < N; i++) if (ref_mem[i] == MATCH) return 1'b1;
      return 1'b0;
   endfunction

   task automatic clear_ref(input logic [SW-1:0] v);
      for (int i = 0; i < N; i++) ref_mem[i] = v;
   endtask

   task automatic do_reset_load;
      for (int i = 0; i < N; i++) bulk_val[i] = ref_mem[i];
      bulk_en = 1'b1;
      arm1 = 1'b1;
      reset = 1'b1;
      ifc.out_ready = 1'b0;
      ifc.scan_en = 1'b1;
      tick;
      bulk_en = 1'b0;
      arm1 = 1'b0;
      tick;
      reset = 1'b0;
      m_ptr = 0;
      m_miss = 0;
      m_none = 1'b0;
   endtask

   // Entry: first cycle of a SCAN phase; exit: first SCAN cycle after the HOLD phase
   task automatic expect_grant(input int delay, input string tag, output int gnum);
      int d, t, c;
      bit found;
      found = 1'b0;
      d = 0;
      t = 0;
      for (int k = 0; k < N; k++) begin
         if (!found && ref_mem[(m_ptr + k) % N] == MATCH) begin
            found = 1'b1;
            d = k;
            t = (m_ptr + k) % N;
         end
      end
      gnum = t;
      c = 0;
      while (!ifc.out_valid && c < 4 * N) begin
         checks++;
         if (ifc.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_scan_wr: wr_en=%b during scan, want 0", tag, ifc.wr_en);
         end
         tick;
         c++;
      end
      checks++;
      if (c !== d + 1) begin
         errors++;
         $display("FAIL %s_latency: out_valid after %0d cycles, want %0d", tag, c, d + 1);
      end
      checks++;
      if (int'(ifc.out_num) !== t) begin
         errors++;
         $display("FAIL %s_num: out_num=%0d, want %0d", tag, ifc.out_num, t);
      end
      for (int k = 0; k < delay; k++) begin
         tick;
         checks++;
         if (ifc.out_valid !== 1'b1 || int'(ifc.out_num) !== t || ifc.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall: valid=%b num=%0d wr_en=%b, want 1/%0d/0",
                     tag, ifc.out_valid, ifc.out_num, ifc.wr_en, t);
         end
      end
      ifc.out_ready = 1'b1;
      tick;
      ifc.out_ready = 1'b0;
      checks++;
      if (ifc.wr_en !== 1'b1 || int'(ifc.wr_num) !== t || ifc.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_wb: wr_en=%b wr_num=%0d valid=%b, want 1/%0d/0",
                  tag, ifc.wr_en, ifc.wr_num, ifc.out_valid, t);
      end
      checks++;
      if (int'(ifc.rd_num) !== (t + 1) % N) begin
         errors++;
         $display("FAIL %s_ptr: rd_num=%0d, want %0d", tag, ifc.rd_num, (t + 1) % N);
      end
      tick;
      checks++;
      if (ifc.wr_en !== 1'b0 || mem[t] !== NEWS) begin
         errors++;
         $display("FAIL %s_store: wr_en=%b store=%0d, want 0/%0d", tag, ifc.wr_en, mem[t], NEWS);
      end
      ref_mem[t] = NEWS;
      m_ptr = (t + 1) % N;
      m_miss = 0;
      m_none = 1'b0;
      tick;
   endtask

   // mode 0: scan_en=1, mode 1: scan_en=0, mode 2: random; store holds no match
   task automatic scan_idle(input int ncyc, input int mode, input string tag);
      bit en;
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         checks++;
         if (int'(ifc.rd_num) !== m_ptr || ifc.none_rdy !== m_none ||
             ifc.out_valid !== 1'b0 || ifc.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle cyc%0d: ptr=%0d none=%b valid=%b wr=%b, want %0d/%b/0/0",
                     tag, cyc, ifc.rd_num, ifc.none_rdy, ifc.out_valid, ifc.wr_en, m_ptr, m_none);
         end
         en = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         ifc.scan_en = en;
         if (en) begin
            m_none = (m_miss == N - 1);
            m_miss = m_none ? 0 : m_miss + 1;
            m_ptr = (m_ptr + 1) % N;
         end else begin
            m_none = 1'b0;
         end
         tick;
      end
      ifc.scan_en = 1'b1;
   endtask

   task automatic test_reset;
      clear_ref(2'd0);
      do_reset_load;
      checks++;
      if (ifc.out_valid !== 1'b0 || ifc.wr_en !== 1'b0 || ifc.none_rdy !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: valid=%b wr=%b none=%b, want 0/0/0",
                  ifc.out_valid, ifc.wr_en, ifc.none_rdy);
      end
      checks++;
      if (ifc.rd_num !== 3'd0 || ifc.out_num !== 3'd0 || ifc.wr_num !== 3'd0) begin
         errors++;
         $display("FAIL reset_nums: rd=%0d out=%0d wr=%0d, want 0/0/0",
                  ifc.rd_num, ifc.out_num, ifc.wr_num);
      end
   endtask

   task automatic test_single;
      int g;
      clear_ref(2'd0);
      ref_mem[3] = MATCH;
      do_reset_load;
      expect_grant(0, "single", g);
      scan_idle(18, 0, "single_after");
   endtask

   task automatic test_freeze;
      scan_idle(10, 1, "freeze");
      scan_idle(24, 2, "rand_en");
   endtask

   task automatic test_order;
      int g;
      clear_ref(2'd3);
      ref_mem[1] = MATCH;
      ref_mem[4] = MATCH;
      do_reset_load;
      expect_grant(0, "order_a", g);
      checks++;
      if (g !== 1) begin errors++; $display("FAIL order_first: got %0d, want 1", g); end
      expect_grant(0, "order_b", g);
      checks++;
      if (g !== 4) begin errors++; $display("FAIL order_second: got %0d, want 4", g); end
      ref_mem[1] = MATCH;
      ref_mem[4] = MATCH;
      for (int i = 0; i < N; i++) bulk_val[i] = ref_mem[i];
      bulk_en = 1'b1;
      tick;
      bulk_en = 1'b0;
      m_ptr = (m_ptr + 1) % N;
      expect_grant(0, "order_wrap", g);
      checks++;
      if (g !== 1) begin errors++; $display("FAIL order_wrap_num: got %0d, want 1", g); end
   endtask

   task automatic test_stall;
      int g;
      clear_ref(NEWS);
      ref_mem[2] = MATCH;
      do_reset_load;
      expect_grant(10, "stall", g);
   endtask

   task automatic test_reset_grant;
      int c;
      clear_ref(NEWS);
      ref_mem[5] = MATCH;
      do_reset_load;
      c = 0;
      while (!ifc.out_valid && c < 20) begin
         tick;
         c++;
      end
      tick;
      tick;
      reset = 1'b1;
      tick;
      checks++;
      if (ifc.out_valid !== 1'b0 || ifc.wr_en !== 1'b0 || ifc.rd_num !== 3'd0) begin
         errors++;
         $display("FAIL rstgrant: valid=%b wr=%b ptr=%0d, want 0/0/0",
                  ifc.out_valid, ifc.wr_en, ifc.rd_num);
      end
      reset = 1'b0;
      tick;
      tick;
      for (int i = 0; i < N; i++) begin
         checks++;
         if (mem[i] !== ref_mem[i]) begin
            errors++;
            $display("FAIL rstgrant_store[%0d]: got %0d, want %0d", i, mem[i], ref_mem[i]);
         end
      end
   endtask

   task automatic test_random;
      int g;
      logic [SW-1:0] others [3];
      others[0] = 2'd0;
      others[1] = 2'd2;
      others[2] = 2'd3;
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < N; i++)
            ref_mem[i] = ($urandom_range(0, 2) == 0) ? MATCH : others[$urandom_range(0, 2)];
         do_reset_load;
         while (any_match()) expect_grant(int'($urandom_range(0, 3)), "rand", g);
         scan_idle(8, 2, "rand_tail");
      end
   endtask

   task automatic test_single_thread;
      bit prev_hs, prev_wr, hs;
      int last_hs, n_hs;
      prev_hs = 1'b0;
      prev_wr = 1'b0;
      last_hs = -1;
      n_hs = 0;
      arm1 = 1'b1;
      reset = 1'b1;
      tick;
      arm1 = 1'b0;
      tick;
      reset = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         checks++;
         if (ifc1.wr_en !== prev_hs || ifc1.rd_num !== 1'b0) begin
            errors++;
            $display("FAIL n1_wr cyc%0d: wr_en=%b ptr=%0d, want %b/0", cyc, ifc1.wr_en, ifc1.rd_num, prev_hs);
         end
         hs = ifc1.out_valid && ifc1.out_ready;
         if (hs) begin
            checks++;
            if (last_hs >= 0 && cyc - last_hs != HOLDOFF + 2) begin
               errors++;
               $display("FAIL n1_spacing: %0d cycles, want %0d", cyc - last_hs, HOLDOFF + 2);
            end else if (last_hs < 0 && cyc != 1) begin
               errors++;
               $display("FAIL n1_first: grant at cycle %0d, want 1", cyc);
            end
            last_hs = cyc;
            n_hs++;
         end
         arm1 = prev_wr;
         prev_wr = ifc1.wr_en;
         prev_hs = hs;
         tick;
      end
      arm1 = 1'b0;
      checks++;
      if (n_hs !== 10) begin
         errors++;
         $display("FAIL n1_count: %0d grants, want 10", n_hs);
      end
   endtask

   initial begin
      reset = 1'b1;
      bulk_en = 1'b0;
      arm1 = 1'b0;
      ifc.scan_en = 1'b1;
      ifc.out_ready = 1'b0;
      ifc1.scan_en = 1'b1;
      ifc1.out_ready = 1'b1;
      for (int i = 0; i < N; i++) bulk_val[i] = 2'd0;
      tick;
      test_reset;
      test_single;
      test_freeze;
      test_order;
      test_stall;
      test_reset_grant;
      test_random;
      test_single_thread;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
